// File: rtl/clint.sv
// -----------------------------------------------------------------------------
// clint - core-local interruptor, a slave on the CPU data bus (mem_* protocol).
//
// Holds the 64-bit machine timer (mtime), its compare register (mtimecmp) and
// the machine software-interrupt bit (msip). It drives the core's timer and
// software interrupt inputs. The bus handshake matches the ram block: a request
// is accepted in IDLE and answered with a one-cycle mem_ready pulse a cycle
// later.
//
// Parameters:
//   BASE_ADDR  window base; only the low 16 address bits are decoded here
//   TICK_DIV   clocks per mtime increment (>= 1)
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   mem_address   byte address of the request
//   mem_wdata     write data
//   mem_wsel      byte write enables, all zero for a read
//   mem_valid     request, held until mem_ready
//   mem_rdata     read data, non-zero only while mem_ready is high
//   mem_ready     one-cycle completion pulse
//   mem_error     bus error, only while mem_ready is high
//   xint_mtip     timer interrupt pending (mtime >= mtimecmp)
//   xint_msip     software interrupt pending (msip bit 0)
// -----------------------------------------------------------------------------
module clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wsel,
  input  logic        mem_valid,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        xint_mtip,
  output logic        xint_msip
);

  localparam logic [31:0] TICK_LAST = TICK_DIV - 1;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [63:0] mtime;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp;
  logic [63:0] mtimecmp_next;
  logic        msip;
  logic        msip_next;
  logic [31:0] prescaler;
  logic [31:0] prescaler_next;
  logic        mtip;
  logic [31:0] rdata_q;
  logic        error_q;

  logic [15:0] offset;
  logic        sel_msip;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_time_lo;
  logic        sel_time_hi;
  logic        bad_access;
  logic        accept;
  logic        is_write;
  logic        do_write;
  logic        tick;
  logic [31:0] read_mux;

  // The upper address bits are decoded by the top level.
  logic unused_upper_addr;
  assign unused_upper_addr = ^mem_address[31:16];

  // Byte-lane merge of write data into an existing 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [3:0]  sel);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        result[8*b +: 8] = data[8*b +: 8];
      end
    end
    return result;
  endfunction

  // Address decode. The base's low bits are zero for a 64 KiB aligned window,
  // so subtracting them only matters if the window is ever placed off-grid.
  assign offset      = mem_address[15:0] - BASE_ADDR[15:0];
  assign sel_msip    = (offset == 16'h0000);
  assign sel_cmp_lo  = (offset == 16'h4000);
  assign sel_cmp_hi  = (offset == 16'h4004);
  assign sel_time_lo = (offset == 16'hBFF8);
  assign sel_time_hi = (offset == 16'hBFFC);
  assign bad_access  = (mem_address[1:0] != 2'b00) ||
                       !(sel_msip || sel_cmp_lo || sel_cmp_hi || sel_time_lo || sel_time_hi);

  assign accept   = (state == IDLE) && mem_valid && !mem_ready;
  assign is_write = (mem_wsel != 4'b0000);
  assign do_write = accept && is_write && !bad_access;
  assign tick     = (prescaler == TICK_LAST);

  // Read data mux over the current register values.
  always_comb begin
    read_mux = 32'h0;
    if (sel_msip)    read_mux = {31'h0, msip};
    if (sel_cmp_lo)  read_mux = mtimecmp[31:0];
    if (sel_cmp_hi)  read_mux = mtimecmp[63:32];
    if (sel_time_lo) read_mux = mtime[31:0];
    if (sel_time_hi) read_mux = mtime[63:32];
  end

  // Next values of the timer, compare and msip registers. A bus write to an
  // mtime half replaces the tick for that cycle entirely, so the untouched half
  // keeps its old value and no carry crosses between halves.
  always_comb begin
    prescaler_next = tick ? 32'h0 : prescaler + 32'd1;
    mtime_next     = tick ? mtime + 64'd1 : mtime;
    mtimecmp_next  = mtimecmp;
    msip_next      = msip;
    if (do_write && sel_time_lo) begin
      mtime_next = {mtime[63:32], merge_bytes(mtime[31:0], mem_wdata, mem_wsel)};
    end
    if (do_write && sel_time_hi) begin
      mtime_next = {merge_bytes(mtime[63:32], mem_wdata, mem_wsel), mtime[31:0]};
    end
    if (do_write && sel_cmp_lo) begin
      mtimecmp_next[31:0] = merge_bytes(mtimecmp[31:0], mem_wdata, mem_wsel);
    end
    if (do_write && sel_cmp_hi) begin
      mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], mem_wdata, mem_wsel);
    end
    if (do_write && sel_msip && mem_wsel[0]) begin
      msip_next = mem_wdata[0];
    end
  end

  // Handshake next-state: one response cycle per accepted request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Timer state plus the registered timer-interrupt compare; the compare looks
  // at the register contents, so mtip trails the condition by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime     <= 64'h0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip      <= 1'b0;
      prescaler <= 32'h0;
      mtip      <= 1'b0;
    end else begin
      mtime     <= mtime_next;
      mtimecmp  <= mtimecmp_next;
      msip      <= msip_next;
      prescaler <= prescaler_next;
      mtip      <= (mtime >= mtimecmp);
    end
  end

  // Response capture: writes and errored accesses return zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else if (accept) begin
      rdata_q <= (is_write || bad_access) ? 32'h0 : read_mux;
      error_q <= bad_access;
    end
  end

  assign mem_ready = (state == RESP);
  assign mem_rdata = mem_ready ? rdata_q : 32'h0;
  assign mem_error = mem_ready ? error_q : 1'b0;
  assign xint_mtip = mtip;
  assign xint_msip = msip;

endmodule
